// File: rtl/rtc_pkg.sv
// Shared types and constants for the real-time-of-day / alarm core.
package rtc_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } rtc_state_e;

    // True when a requested time of day names a real hh:mm:ss on this clock.
    function automatic logic time_in_range(
        input logic [HR_W-1:0]  hr,
        input logic [MIN_W-1:0] mn,
        input logic [SEC_W-1:0] sc,
        input logic [HR_W-1:0]  hr_limit
    );
        return (hr < hr_limit) && (mn <= MIN_MAX) && (sc <= SEC_MAX);
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the board clock down to a one-cycle tick per second.
module rtc_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = (cnt_r == CNT_LAST);

    // Free-running divider; a clear restarts the second from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clr || tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rtc_alarm_core.sv
// Time-of-day counters, per-channel alarm match and the shared ring/snooze/dismiss
// controller driving the buzzer.
module rtc_alarm_core
    import rtc_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int HOURS_PER_DAY = 24,
    parameter int NUM_ALARMS    = 2,
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_SECS   = 300
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        set_valid,
    input  logic [HR_W-1:0]             set_hr,
    input  logic [MIN_W-1:0]            set_min,
    input  logic [SEC_W-1:0]            set_sec,
    output logic                        set_err,
    input  logic [NUM_ALARMS-1:0]       alarm_en,
    input  logic [HR_W*NUM_ALARMS-1:0]  alarm_hr,
    input  logic [MIN_W*NUM_ALARMS-1:0] alarm_min,
    input  logic                        snooze,
    input  logic                        dismiss,
    output logic [HR_W-1:0]             hr_o,
    output logic [MIN_W-1:0]            min_o,
    output logic [SEC_W-1:0]            sec_o,
    output logic                        sec_pulse,
    output logic                        ring,
    output logic [2:0]                  ring_id,
    output logic [1:0]                  state_o
);

    localparam int                RING_W    = $clog2(RING_SECS + 1);
    localparam int                SNZ_W     = $clog2(SNOOZE_SECS + 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
    localparam logic [HR_W-1:0]   HR_LAST   = HR_W'(HOURS_PER_DAY - 1);
    localparam logic [HR_W-1:0]   HR_LIMIT  = HR_W'(HOURS_PER_DAY);

    logic                  tick_s;
    logic                  set_ok_s;
    logic                  match_s;
    logic [NUM_ALARMS-1:0] hit_s;
    logic [2:0]            match_id_s;
    logic [2:0]            ring_id_nxt_s;
    rtc_state_e            state_r;
    rtc_state_e            state_nxt_s;
    logic [RING_W-1:0]     ring_cnt_r;
    logic [RING_W-1:0]     ring_cnt_nxt_s;
    logic [SNZ_W-1:0]      snz_cnt_r;
    logic [SNZ_W-1:0]      snz_cnt_nxt_s;

    assign set_ok_s = set_valid & time_in_range(set_hr, set_min, set_sec, HR_LIMIT);
    assign state_o  = state_r;

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (set_ok_s),
        .tick  (tick_s)
    );

    // Time of day: an accepted set overrides a tick landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr_o  <= '0;
            min_o <= '0;
            sec_o <= '0;
        end else if (set_ok_s) begin
            hr_o  <= set_hr;
            min_o <= set_min;
            sec_o <= set_sec;
        end else if (tick_s) begin
            if (sec_o == SEC_MAX) begin
                sec_o <= '0;
                if (min_o == MIN_MAX) begin
                    min_o <= '0;
                    hr_o  <= (hr_o == HR_LAST) ? '0 : hr_o + 5'd1;
                end else begin
                    min_o <= min_o + 6'd1;
                end
            end else begin
                sec_o <= sec_o + 6'd1;
            end
        end
    end

    // Update strobe for alarm evaluation and the rejected-set flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_pulse <= tick_s | set_ok_s;
            set_err   <= set_valid & ~set_ok_s;
        end
    end

    // Alarm hits are only looked at while the freshly updated time is on the outputs.
    always_comb begin
        hit_s      = '0;
        match_id_s = 3'd0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit_s[i] = sec_pulse & alarm_en[i] & (sec_o == 6'd0)
                     & (hr_o  == alarm_hr[HR_W*i +: HR_W])
                     & (min_o == alarm_min[MIN_W*i +: MIN_W]);
        end
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            match_id_s = hit_s[i] ? 3'(i) : match_id_s;
        end
        match_s = |hit_s;
    end

    // Ring controller next state; dismiss beats snooze beats expiry beats a new match.
    always_comb begin
        state_nxt_s    = state_r;
        ring_cnt_nxt_s = ring_cnt_r;
        snz_cnt_nxt_s  = snz_cnt_r;
        ring_id_nxt_s  = ring_id;
        if (dismiss) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (match_s) begin
                        state_nxt_s    = ST_RINGING;
                        ring_cnt_nxt_s = RING_LOAD;
                        ring_id_nxt_s  = match_id_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RINGING: begin
                    if (snooze) begin
                        state_nxt_s   = ST_SNOOZED;
                        snz_cnt_nxt_s = SNZ_LOAD;
                    end else if (tick_s) begin
                        ring_cnt_nxt_s = ring_cnt_r - RING_W'(1);
                        state_nxt_s    = (ring_cnt_r <= RING_W'(1)) ? ST_IDLE : ST_RINGING;
                    end else begin
                        state_nxt_s = ST_RINGING;
                    end
                end
                ST_SNOOZED: begin
                    if (tick_s && (snz_cnt_r <= SNZ_W'(1))) begin
                        state_nxt_s    = ST_RINGING;
                        snz_cnt_nxt_s  = '0;
                        ring_cnt_nxt_s = RING_LOAD;
                    end else if (match_s) begin
                        state_nxt_s    = ST_RINGING;
                        ring_cnt_nxt_s = RING_LOAD;
                        ring_id_nxt_s  = match_id_s;
                    end else if (tick_s) begin
                        snz_cnt_nxt_s = snz_cnt_r - SNZ_W'(1);
                    end else begin
                        state_nxt_s = ST_SNOOZED;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Controller registers; ring mirrors the state it is entering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ring_cnt_r <= '0;
            snz_cnt_r  <= '0;
            ring_id    <= 3'd0;
            ring       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ring_cnt_r <= ring_cnt_nxt_s;
            snz_cnt_r  <= snz_cnt_nxt_s;
            ring_id    <= ring_id_nxt_s;
            ring       <= (state_nxt_s == ST_RINGING);
        end
    end

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Bench for rtc_alarm_core: a 24-hour and a 12-hour instance share all inputs and are
// compared every cycle against a seconds-of-day model, plus hand-computed checkpoints.
module tb_rtc_alarm_core;

    localparam int TD   = 4;
    localparam int RING = 3;
    localparam int SNZ  = 5;
    localparam int NA   = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        set_valid = 1'b0;
    logic [4:0]  set_hr    = 5'd0;
    logic [5:0]  set_min   = 6'd0;
    logic [5:0]  set_sec   = 6'd0;
    logic [1:0]  alarm_en  = 2'b00;
    logic [9:0]  alarm_hr  = 10'd0;
    logic [11:0] alarm_min = 12'd0;
    logic        snooze    = 1'b0;
    logic        dismiss   = 1'b0;

    logic       a_err, a_pulse, a_ring, b_err, b_pulse, b_ring;
    logic [4:0] a_hr, b_hr;
    logic [5:0] a_min, a_sec, b_min, b_sec;
    logic [2:0] a_id, b_id;
    logic [1:0] a_st, b_st;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rtc_alarm_core #(.TICK_DIV(TD), .HOURS_PER_DAY(24), .NUM_ALARMS(NA),
                     .RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut_a (
        .clk(clk), .reset(rst_n), .set_valid(set_valid), .set_hr(set_hr),
        .set_min(set_min), .set_sec(set_sec), .set_err(a_err), .alarm_en(alarm_en),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .snooze(snooze), .dismiss(dismiss),
        .hr_o(a_hr), .min_o(a_min), .sec_o(a_sec), .sec_pulse(a_pulse), .ring(a_ring),
        .ring_id(a_id), .state_o(a_st));

    rtc_alarm_core #(.TICK_DIV(TD), .HOURS_PER_DAY(12), .NUM_ALARMS(NA),
                     .RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut_b (
        .clk(clk), .reset(rst_n), .set_valid(set_valid), .set_hr(set_hr),
        .set_min(set_min), .set_sec(set_sec), .set_err(b_err), .alarm_en(alarm_en),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .snooze(snooze), .dismiss(dismiss),
        .hr_o(b_hr), .min_o(b_min), .sec_o(b_sec), .sec_pulse(b_pulse), .ring(b_ring),
        .ring_id(b_id), .state_o(b_st));

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: time as seconds of day, controller as state/seconds-left.
    int m_tod_a = 0, m_tod_b = 0, m_phase_a = 0, m_phase_b = 0;
    bit m_pulse_a = 1'b0, m_pulse_b = 1'b0, m_err_a = 1'b0, m_err_b = 1'b0;
    int m_st = 0, m_ring_left = 0, m_snz_left = 0, m_id = 0;

    always @(posedge clk or negedge rst_n) begin
        bit tick_a, tick_b, ok_a, ok_b, hit;
        int hit_id, set_tod;
        if (!rst_n) begin
            m_tod_a = 0; m_tod_b = 0; m_phase_a = 0; m_phase_b = 0;
            m_pulse_a = 1'b0; m_pulse_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
            m_st = 0; m_ring_left = 0; m_snz_left = 0; m_id = 0;
        end else begin
            tick_a  = (m_phase_a == TD - 1);
            tick_b  = (m_phase_b == TD - 1);
            ok_a    = set_valid && set_hr < 24 && set_min < 60 && set_sec < 60;
            ok_b    = set_valid && set_hr < 12 && set_min < 60 && set_sec < 60;
            set_tod = int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec);
            hit = 1'b0; hit_id = 0;
            if (m_pulse_a) begin
                for (int i = NA - 1; i >= 0; i--) begin
                    if (alarm_en[i] && m_tod_a == int'(alarm_hr[5*i +: 5]) * 3600
                                                + int'(alarm_min[6*i +: 6]) * 60) begin
                        hit = 1'b1; hit_id = i;
                    end
                end
            end
            if (dismiss) m_st = 0;
            else if (m_st == 1) begin
                if (snooze) begin m_st = 2; m_snz_left = SNZ; end
                else if (tick_a) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_st = 0;
                end
            end else if (m_st == 2) begin
                if (tick_a && m_snz_left == 1) begin m_st = 1; m_ring_left = RING; m_snz_left = 0; end
                else begin
                    if (tick_a) m_snz_left--;
                    if (hit) begin m_st = 1; m_ring_left = RING; m_id = hit_id; end
                end
            end else if (hit) begin
                m_st = 1; m_ring_left = RING; m_id = hit_id;
            end
            if (ok_a) begin m_tod_a = set_tod; m_phase_a = 0; end
            else if (tick_a) begin m_tod_a = (m_tod_a + 1) % 86400; m_phase_a = 0; end
            else m_phase_a++;
            if (ok_b) begin m_tod_b = set_tod; m_phase_b = 0; end
            else if (tick_b) begin m_tod_b = (m_tod_b + 1) % 43200; m_phase_b = 0; end
            else m_phase_b++;
            m_pulse_a = tick_a || ok_a;
            m_pulse_b = tick_b || ok_b;
            m_err_a   = set_valid && !ok_a;
            m_err_b   = set_valid && !ok_b;
        end
    end

    // Cycle-by-cycle comparison, just after each active edge.
    always @(posedge clk) begin
        #1;
        check("a_hr",    a_hr,    m_tod_a / 3600);
        check("a_min",   a_min,   (m_tod_a / 60) % 60);
        check("a_sec",   a_sec,   m_tod_a % 60);
        check("a_pulse", a_pulse, int'(m_pulse_a));
        check("a_err",   a_err,   int'(m_err_a));
        check("a_ring",  a_ring,  int'(m_st == 1));
        check("a_id",    a_id,    m_id);
        check("a_state", a_st,    m_st);
        check("b_hr",    b_hr,    m_tod_b / 3600);
        check("b_min",   b_min,   (m_tod_b / 60) % 60);
        check("b_sec",   b_sec,   m_tod_b % 60);
        check("b_pulse", b_pulse, int'(m_pulse_b));
        check("b_err",   b_err,   int'(m_err_b));
    end

    task automatic do_set(input int h, input int m, input int s);
        set_valid = 1'b1; set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_pulse && n < 3 * TD);
        check("pulse_seen", a_pulse, 1);
    endtask

    task automatic pulse_ctl(input bit snz, input bit dis);
        snooze = snz; dismiss = dis;
        @(negedge clk);
        snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic release_and_check();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TD - 1) @(negedge clk);
        check("lit_pre_tick_sec", a_sec, 0);
        check("lit_pre_tick_pulse", a_pulse, 0);
        @(negedge clk);
        check("lit_first_tick_sec", a_sec, 1);
        check("lit_first_tick_pulse", a_pulse, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("lit_rst_hr", a_hr, 0);
        check("lit_rst_state", a_st, 0);
        check("lit_rst_ring", a_ring, 0);
        release_and_check();

        // 24-hour rollover and tick spacing
        do_set(23, 59, 58);
        check("lit_set_a_err", a_err, 0);
        check("lit_set_b_err", b_err, 1);
        check("lit_set_sec", a_sec, 58);
        wait_pulse(n);
        check("lit_period_after_set", n, TD);
        check("lit_59_sec", a_sec, 59);
        check("lit_59_hr", a_hr, 23);
        wait_pulse(n);
        check("lit_period", n, TD);
        check("lit_wrap_hr", a_hr, 0);
        check("lit_wrap_min", a_min, 0);
        check("lit_wrap_sec", a_sec, 0);

        // 12-hour wrap and out-of-range rejection
        do_set(11, 59, 59);
        check("lit_b_set_err", b_err, 0);
        wait_pulse(n);
        check("lit_b_wrap_hr", b_hr, 0);
        check("lit_b_wrap_min", b_min, 0);
        check("lit_b_wrap_sec", b_sec, 0);
        check("lit_a_noon", a_hr, 12);
        do_set(12, 34, 56);
        check("lit_b_hr12_err", b_err, 1);
        check("lit_a_hr12_ok", a_err, 0);
        check("lit_b_unchanged_hr", b_hr, 0);
        check("lit_b_unchanged_sec", b_sec, 0);
        do_set(5, 60, 0);
        check("lit_min60_err", a_err, 1);
        check("lit_min60_keep", a_min, 34);
        do_set(5, 0, 60);
        check("lit_sec60_err", a_err, 1);

        // Alarm 0 at 07:30 rings and times out after RING ticks
        alarm_hr = {5'd0, 5'd7}; alarm_min = {6'd0, 6'd30}; alarm_en = 2'b01;
        do_set(7, 29, 59);
        wait_pulse(n);
        check("lit_eval_cycle_ring", a_ring, 0);
        @(negedge clk);
        check("lit_ring_on", a_ring, 1);
        check("lit_ring_id0", a_id, 0);
        wait_pulse(n);
        wait_pulse(n);
        check("lit_ring_still", a_ring, 1);
        wait_pulse(n);
        check("lit_ring_timeout", a_ring, 0);
        check("lit_ring_timeout_st", a_st, 0);

        // Snooze, re-ring after SNZ ticks, then dismiss
        do_set(7, 29, 59);
        wait_pulse(n);
        @(negedge clk);
        pulse_ctl(1'b1, 1'b0);
        check("lit_snoozed_ring", a_ring, 0);
        check("lit_snoozed_st", a_st, 2);
        repeat (SNZ - 1) wait_pulse(n);
        check("lit_snooze_hold", a_ring, 0);
        wait_pulse(n);
        check("lit_rering", a_ring, 1);
        check("lit_rering_id", a_id, 0);
        pulse_ctl(1'b0, 1'b1);
        check("lit_dismiss_st", a_st, 0);
        check("lit_dismiss_ring", a_ring, 0);

        // Lowest index wins; disabled channel skipped; snooze+dismiss -> IDLE
        alarm_hr = {5'd6, 5'd6}; alarm_min = {6'd0, 6'd0}; alarm_en = 2'b11;
        do_set(5, 59, 59);
        wait_pulse(n);
        @(negedge clk);
        check("lit_both_id", a_id, 0);
        pulse_ctl(1'b0, 1'b1);
        alarm_en = 2'b10;
        do_set(5, 59, 59);
        wait_pulse(n);
        @(negedge clk);
        check("lit_ch1_id", a_id, 1);
        alarm_en = 2'b00;
        @(negedge clk);
        check("lit_cfg_keeps_ring", a_ring, 1);
        pulse_ctl(1'b1, 1'b1);
        check("lit_snz_dis_st", a_st, 0);
        check("lit_snz_dis_id", a_id, 1);

        // A match during snooze re-rings with the new channel
        alarm_hr = {5'd6, 5'd6}; alarm_min = {6'd0, 6'd1}; alarm_en = 2'b11;
        do_set(5, 59, 59);
        wait_pulse(n);
        @(negedge clk);
        check("lit_snzm_id1", a_id, 1);
        pulse_ctl(1'b1, 1'b0);
        @(negedge clk);
        do_set(6, 0, 59);
        check("lit_snzm_still_snz", a_st, 2);
        wait_pulse(n);
        @(negedge clk);
        check("lit_snzm_id0", a_id, 0);
        check("lit_snzm_ring", a_ring, 1);

        // Asynchronous reset in the middle of a ring
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_async_ring", a_ring, 0);
        check("lit_async_hr", a_hr, 0);
        check("lit_async_min", a_min, 0);
        check("lit_async_sec", a_sec, 0);
        check("lit_async_st", a_st, 0);
        release_and_check();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
